chunked_addsub_seq: RTL and testbench

- Multi-cycle, parametrised adder/subtractor, successor to the 4-bit combinational ripple adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry between chunks through a register.
- Adds a subtract mode, a signed-overflow flag and valid/ready handshakes on input and output.
- Used on datapaths where a full-width combinational carry chain would not meet timing.

---
 rtl/chunked_addsub_seq.sv | 136 +++++++++++++
 tb/tb_chunked_addsub_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_addsub_seq.sv
// chunked_addsub_seq
//   Multi-cycle adder/subtractor. A WIDTH-bit operand pair is accepted in
//   IDLE and then processed CHUNK bits per clock. The inter-chunk carry is
//   held in a register, so the combinational carry chain is only CHUNK bits
//   long.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  operand handshake; in_ready is high only in IDLE
//   a, b            operands
//   carry_in        carry into bit 0 (add only; ignored when sub=1)
//   sub             0 = a+b+carry_in, 1 = a-b
//   out_valid/ready result handshake; the result is held while out_valid=1
//   sum             WIDTH-bit result (modulo 2^WIDTH)
//   carry_out       carry out of MSB (in sub mode, 1 = no borrow)
//   overflow        two's-complement signed overflow
//   busy            high in RUN or DONE
module chunked_addsub_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
         $error("chunked_addsub_seq: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;        // b_q already inverted in sub mode
   logic             carry_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_out_q, overflow_q;

   logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
   logic             c_chunk, c_msb_in, last;

   // Current chunk slice. The carry into a chunk's top bit is recovered from
   // the sum bit (s = a ^ b ^ cin), which keeps overflow valid for CHUNK=1.
   always_comb begin
      a_chunk = a_q[idx_q*CHUNK +: CHUNK];
      b_chunk = b_q[idx_q*CHUNK +: CHUNK];
      {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      c_msb_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];
      last     = (idx_q == IW'(NCHUNK - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Handshake outputs decode registered state only, so out_ready never
   // reaches in_ready combinationally.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (last) state_d = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b ^ {WIDTH{sub}};
                  carry_q <= sub ? 1'b1 : carry_in;
                  idx_q   <= '0;
               end
            end
            S_RUN: begin
               sum_q[idx_q*CHUNK +: CHUNK] <= s_chunk;
               carry_q <= c_chunk;
               idx_q   <= idx_q + 1'b1;
               if (last) begin
                  carry_out_q <= c_chunk;
                  overflow_q  <= c_msb_in ^ c_chunk;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum       = sum_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_chunked_addsub_seq.sv
// Self-checking bench for chunked_addsub_seq. Three instances share clk and
// rst_n: index 0 is CHUNK=4, index 1 is CHUNK=16, index 2 is CHUNK=1
// (all WIDTH=16). Inputs are driven 1 time unit after a rising edge and
// outputs are sampled at the same point.
module tb_chunked_addsub_seq;

   logic        clk;
   logic        rst_n;
   logic        in_valid_s  [3];
   logic        in_ready_s  [3];
   logic [15:0] a_s         [3];
   logic [15:0] b_s         [3];
   logic        carry_in_s  [3];
   logic        sub_s       [3];
   logic        out_valid_s [3];
   logic        out_ready_s [3];
   logic [15:0] sum_s       [3];
   logic        carry_out_s [3];
   logic        overflow_s  [3];
   logic        busy_s      [3];

   int checks   = 0;
   int failures = 0;
   int nch [3] = '{4, 1, 16};

   chunked_addsub_seq #(.WIDTH(16), .CHUNK(4)) u_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
      .a(a_s[0]), .b(b_s[0]), .carry_in(carry_in_s[0]), .sub(sub_s[0]),
      .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .sum(sum_s[0]),
      .carry_out(carry_out_s[0]), .overflow(overflow_s[0]), .busy(busy_s[0]));

   chunked_addsub_seq #(.WIDTH(16), .CHUNK(16)) u_c16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
      .a(a_s[1]), .b(b_s[1]), .carry_in(carry_in_s[1]), .sub(sub_s[1]),
      .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .sum(sum_s[1]),
      .carry_out(carry_out_s[1]), .overflow(overflow_s[1]), .busy(busy_s[1]));

   chunked_addsub_seq #(.WIDTH(16), .CHUNK(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
      .a(a_s[2]), .b(b_s[2]), .carry_in(carry_in_s[2]), .sub(sub_s[2]),
      .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .sum(sum_s[2]),
      .carry_out(carry_out_s[2]), .overflow(overflow_s[2]), .busy(busy_s[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Present one operand pair to DUT d (must be in IDLE), wait for out_valid
   // (bounded), capture the result, then consume it with out_ready.
   // lat = edges from the accepting edge to out_valid (101 on timeout).
   task automatic run_op(input int d, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts, output logic [15:0] rs,
                         output logic rc, output logic ro, output int lat);
      in_valid_s[d] = 1'b1; a_s[d] = ta; b_s[d] = tb; carry_in_s[d] = tc; sub_s[d] = ts;
      tick();
      in_valid_s[d] = 1'b0; a_s[d] = 16'hDEAD; b_s[d] = 16'hBEEF; carry_in_s[d] = ~tc; sub_s[d] = ~ts;
      lat = 0;
      while (out_valid_s[d] !== 1'b1 && lat <= 100) begin
         tick();
         lat++;
      end
      rs = sum_s[d]; rc = carry_out_s[d]; ro = overflow_s[d];
      out_ready_s[d] = 1'b1;
      tick();
      out_ready_s[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid_s[i] = 0; a_s[i] = 0; b_s[i] = 0; carry_in_s[i] = 0; sub_s[i] = 0; out_ready_s[i] = 0;
      end
      #23;
      checks++; if (sum_s[0] !== 16'h0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum_s[0]); end
      checks++; if (carry_out_s[0] !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", carry_out_s[0]); end
      checks++; if (overflow_s[0] !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow_s[0]); end
      checks++; if (out_valid_s[0] !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_s[0]); end
      checks++; if (busy_s[0] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_s[0]); end
      @(negedge clk); rst_n = 1'b1;
      tick();
      checks++; if (in_ready_s[0] !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_s[0]); end
   endtask

   task automatic test_add();
      logic [15:0] s; logic c, o; int lat;
      run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, s, c, o, lat);
      checks++; if (lat !== 4) begin failures++; $display("FAIL add_latency got=%0d exp=4", lat); end
      checks++; if (s !== 16'h5555) begin failures++; $display("FAIL add_sum got=%h exp=5555", s); end
      checks++; if (c !== 1'b0) begin failures++; $display("FAIL add_cout got=%b exp=0", c); end
      checks++; if (o !== 1'b0) begin failures++; $display("FAIL add_ovf got=%b exp=0", o); end
   endtask

   task automatic test_carry_ripple();
      logic [15:0] s; logic c, o; int lat;
      run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
      checks++; if (s !== 16'h0000) begin failures++; $display("FAIL ripple_sum got=%h exp=0000", s); end
      checks++; if (c !== 1'b1) begin failures++; $display("FAIL ripple_cout got=%b exp=1", c); end
      checks++; if (o !== 1'b0) begin failures++; $display("FAIL ripple_ovf got=%b exp=0", o); end
      run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
      checks++; if (s !== 16'h8000) begin failures++; $display("FAIL posovf_sum got=%h exp=8000", s); end
      checks++; if (c !== 1'b0) begin failures++; $display("FAIL posovf_cout got=%b exp=0", c); end
      checks++; if (o !== 1'b1) begin failures++; $display("FAIL posovf_ovf got=%b exp=1", o); end
      run_op(0, 16'h0001, 16'h0001, 1'b1, 1'b0, s, c, o, lat);
      checks++; if (s !== 16'h0003) begin failures++; $display("FAIL add_cin_sum got=%h exp=0003", s); end
   endtask

   task automatic test_subtract();
      logic [15:0] s; logic c, o; int lat;
      run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, s, c, o, lat);
      checks++; if (s !== 16'hFFFE) begin failures++; $display("FAIL sub_neg_sum got=%h exp=fffe", s); end
      checks++; if (c !== 1'b0) begin failures++; $display("FAIL sub_neg_cout got=%b exp=0", c); end
      checks++; if (o !== 1'b0) begin failures++; $display("FAIL sub_neg_ovf got=%b exp=0", o); end
      run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, s, c, o, lat);
      checks++; if (s !== 16'h7FFF) begin failures++; $display("FAIL sub_ovf_sum got=%h exp=7fff", s); end
      checks++; if (c !== 1'b1) begin failures++; $display("FAIL sub_ovf_cout got=%b exp=1", c); end
      checks++; if (o !== 1'b1) begin failures++; $display("FAIL sub_ovf_ovf got=%b exp=1", o); end
   endtask

   task automatic test_backpressure();
      logic [15:0] s; logic c, o; int lat;
      int bad_sum = 0, bad_rdy = 0, bad_vld = 0;
      in_valid_s[0] = 1'b1; a_s[0] = 16'h1111; b_s[0] = 16'h2222; carry_in_s[0] = 0; sub_s[0] = 0;
      tick();
      a_s[0] = 16'hAAAA; b_s[0] = 16'h5555; sub_s[0] = 1'b1;  // in_valid stays high
      lat = 0;
      while (out_valid_s[0] !== 1'b1 && lat <= 100) begin tick(); lat++; end
      checks++; if (lat !== 4) begin failures++; $display("FAIL bp_latency got=%0d exp=4", lat); end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (sum_s[0] !== 16'h3333) bad_sum++;
         if (in_ready_s[0] !== 1'b0) bad_rdy++;
         if (out_valid_s[0] !== 1'b1) bad_vld++;
      end
      checks++; if (bad_sum != 0) begin failures++; $display("FAIL bp_sum_held got=%0d_bad_cycles last=%h exp=3333", bad_sum, sum_s[0]); end
      checks++; if (bad_rdy != 0) begin failures++; $display("FAIL bp_in_ready got=%0d_bad_cycles exp=0", bad_rdy); end
      checks++; if (bad_vld != 0) begin failures++; $display("FAIL bp_out_valid got=%0d_bad_cycles exp=0", bad_vld); end
      out_ready_s[0] = 1'b1; in_valid_s[0] = 1'b0;
      tick();
      out_ready_s[0] = 1'b0;
      checks++; if (out_valid_s[0] !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%b exp=0", out_valid_s[0]); end
      checks++; if (in_ready_s[0] !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", in_ready_s[0]); end
      checks++; if (sum_s[0] !== 16'h3333) begin failures++; $display("FAIL bp_idle_hold got=%h exp=3333", sum_s[0]); end
      run_op(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, s, c, o, lat);
      checks++; if (s !== 16'h1010 || lat !== 4) begin failures++; $display("FAIL bp_next_op got=%h/%0d exp=1010/4", s, lat); end
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] s; logic c, o; int lat; int seen = 0;
      in_valid_s[0] = 1'b1; a_s[0] = 16'hFFFF; b_s[0] = 16'hFFFF; carry_in_s[0] = 1; sub_s[0] = 0;
      tick();
      in_valid_s[0] = 1'b0;
      tick(); tick();   // two RUN cycles done
      checks++; if (busy_s[0] !== 1'b1 || sum_s[0] === 16'h0) begin failures++; $display("FAIL midrun_before got=busy%b/%h exp=busy1/nonzero", busy_s[0], sum_s[0]); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (sum_s[0] !== 16'h0 || busy_s[0] !== 1'b0 || out_valid_s[0] !== 1'b0)
         begin failures++; $display("FAIL midrun_async_clear got=%h/%b/%b exp=0000/0/0", sum_s[0], busy_s[0], out_valid_s[0]); end
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin tick(); if (out_valid_s[0] === 1'b1) seen++; end
      checks++; if (seen != 0) begin failures++; $display("FAIL midrun_no_valid got=%0d exp=0", seen); end
      run_op(0, 16'h0001, 16'h0002, 1'b0, 1'b0, s, c, o, lat);
      checks++; if (s !== 16'h0003 || lat !== 4) begin failures++; $display("FAIL midrun_after got=%h/%0d exp=0003/4", s, lat); end
   endtask

   task automatic test_param_sweep();
      // {a, b, cin, sub, sum, cout, ovf}
      logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'hFFFF, 16'h4000, 16'h0003};
      logic [15:0] vb [8] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'hFFFF, 16'h4000, 16'h0003};
      logic        vc [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
      logic        vs [8] = '{0, 0, 0, 1, 1, 0, 0, 1};
      logic [15:0] es [8] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'hFFFF, 16'h8000, 16'h0000};
      logic        ec [8] = '{0, 1, 0, 0, 1, 1, 0, 1};
      logic        eo [8] = '{0, 0, 1, 0, 1, 0, 1, 0};
      logic [15:0] s; logic c, o; int lat;
      for (int d = 1; d < 3; d++) begin
         for (int i = 0; i < 8; i++) begin
            run_op(d, va[i], vb[i], vc[i], vs[i], s, c, o, lat);
            checks++;
            if (s !== es[i] || c !== ec[i] || o !== eo[i] || lat !== nch[d]) begin
               failures++;
               $display("FAIL sweep_d%0d_v%0d got=%h/%b/%b/lat%0d exp=%h/%b/%b/lat%0d",
                        d, i, s, c, o, lat, es[i], ec[i], eo[i], nch[d]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] ra, rb, s, ms; logic rc, rsub, c, o, mc, mo; int lat;
      logic [16:0] full;
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rsub = 1'(i % 2);
            if (rsub) begin
               full = {1'b0, ra} - {1'b0, rb};
               mc   = (ra >= rb);
               ms   = full[15:0];
               mo   = (ra[15] != rb[15]) && (ms[15] != ra[15]);
            end else begin
               full = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
               mc   = full[16];
               ms   = full[15:0];
               mo   = (ra[15] == rb[15]) && (ms[15] != ra[15]);
            end
            run_op(d, ra, rb, rc, rsub, s, c, o, lat);
            checks++;
            if (s !== ms || c !== mc || o !== mo || lat !== nch[d]) begin
               failures++;
               $display("FAIL rand_d%0d_%0d a=%h b=%h cin=%b sub=%b got=%h/%b/%b/lat%0d exp=%h/%b/%b/lat%0d",
                        d, i, ra, rb, rc, rsub, s, c, o, lat, ms, mc, mo, nch[d]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_carry_ripple();
      test_subtract();
      test_backpressure();
      test_reset_mid_run();
      test_param_sweep();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
